// File: rtl/somador_serial.sv
// rtl/somador_serial.sv - digit-serial adder/subtractor with valid/ready handshakes
//
// Purpose:
//   Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, least
//   significant chunk first, through one CHUNK-bit ripple stage whose carry is
//   held in a register between cycles. Subtraction is a + ~b + 1: the operand
//   b is inverted on capture and the initial carry is set to 1.
//
// Parameters:
//   WIDTH     operand/result width in bits (>= 1)
//   CHUNK     bits processed per clock; WIDTH must be a multiple of CHUNK
//
// Ports:
//   clk       clock, all state changes on the rising edge
//   rst       synchronous active-high reset
//   in_valid  operand set presented
//   in_ready  operands accepted this cycle (block is IDLE)
//   a, b      operands
//   sub       0: a+b, 1: a-b, sampled with the operands
//   out_valid result available (block is DONE)
//   out_ready consumer takes the result
//   s         registered sum/difference
//   cout      carry out of the MSB (for sub: 1 = no borrow, a >= b unsigned)
//   ovf       two's-complement overflow

module somador_serial #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / CHUNK;
  // Chunk index needs at least one bit even when N == 1.
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic             r_carry;
  logic [KW-1:0]    r_k;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_ovf;

  logic [CHUNK-1:0] w_chunk_a;
  logic [CHUNK-1:0] w_chunk_b;
  logic [CHUNK:0]   w_sum;
  logic             w_c_msb_in;

  // Select the active chunk with a decoded mux rather than a variable part
  // select, so an unused index value can never address past the operand.
  always_comb begin
    w_chunk_a = '0;
    w_chunk_b = '0;
    for (int i = 0; i < N; i++) begin
      if (r_k == KW'(i)) begin
        w_chunk_a = r_op_a[i*CHUNK +: CHUNK];
        w_chunk_b = r_op_b[i*CHUNK +: CHUNK];
      end
    end
  end

  assign w_sum = {1'b0, w_chunk_a} + {1'b0, w_chunk_b} + {{CHUNK{1'b0}}, r_carry};

  // Carry into the top bit of the chunk, recovered from the sum bit: on the
  // last chunk this is the carry into bit WIDTH-1.
  assign w_c_msb_in = w_chunk_a[CHUNK-1] ^ w_chunk_b[CHUNK-1] ^ w_sum[CHUNK-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_carry <= 1'b0;
      r_k     <= '0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op_a  <= a;
            r_op_b  <= sub ? ~b : b;
            r_carry <= sub;
            r_k     <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          for (int i = 0; i < N; i++) begin
            if (r_k == KW'(i)) begin
              r_s[i*CHUNK +: CHUNK] <= w_sum[CHUNK-1:0];
            end
          end
          r_carry <= w_sum[CHUNK];
          if (r_k == K_LAST) begin
            r_cout  <= w_sum[CHUNK];
            r_ovf   <= w_sum[CHUNK] ^ w_c_msb_in;
            r_state <= S_DONE;
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign s         = r_s;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_somador_serial.sv
// tb/tb_somador_serial.sv - directed and swept checks of somador_serial
module tb_somador_serial;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // DUT 0: 16/4
  logic        iv0 = 0, or0 = 0, sb0 = 0, ir0, ov0, co0, of0;
  logic [15:0] a0 = 0, b0 = 0, s0;
  // DUT 1: 8/8
  logic        iv1 = 0, or1 = 0, sb1 = 0, ir1, ov1, co1, of1;
  logic [7:0]  a1 = 0, b1 = 0, s1;
  // DUT 2: 12/3
  logic        iv2 = 0, or2 = 0, sb2 = 0, ir2, ov2, co2, of2;
  logic [11:0] a2 = 0, b2 = 0, s2;

  somador_serial #(.WIDTH(16), .CHUNK(4)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0), .sub(sb0),
    .out_valid(ov0), .out_ready(or0), .s(s0), .cout(co0), .ovf(of0));
  somador_serial #(.WIDTH(8), .CHUNK(8)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .sub(sb1),
    .out_valid(ov1), .out_ready(or1), .s(s1), .cout(co1), .ovf(of1));
  somador_serial #(.WIDTH(12), .CHUNK(3)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2), .sub(sb2),
    .out_valid(ov2), .out_ready(or2), .s(s2), .cout(co2), .ovf(of2));

  int cur_sel = 0;
  logic        m_ir, m_ov, m_co, m_of;
  logic [15:0] m_s;
  always_comb begin
    case (cur_sel)
      1:       begin m_ir = ir1; m_ov = ov1; m_co = co1; m_of = of1; m_s = {8'h00, s1}; end
      2:       begin m_ir = ir2; m_ov = ov2; m_co = co2; m_of = of2; m_s = {4'h0, s2}; end
      default: begin m_ir = ir0; m_ov = ov0; m_co = co0; m_of = of0; m_s = s0; end
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic [15:0] ia, input logic [15:0] ib, input logic isub);
    case (sel)
      1:       begin iv1 = v; a1 = ia[7:0];  b1 = ib[7:0];  sb1 = isub; end
      2:       begin iv2 = v; a2 = ia[11:0]; b2 = ib[11:0]; sb2 = isub; end
      default: begin iv0 = v; a0 = ia;       b0 = ib;       sb0 = isub; end
    endcase
  endtask

  task automatic set_ready(input int sel, input logic v);
    case (sel)
      1:       or1 = v;
      2:       or2 = v;
      default: or0 = v;
    endcase
  endtask

  // Independent reference: sign-rule overflow, carry from a wide sum.
  task automatic model(input int w, input logic [15:0] ia, input logic [15:0] ib, input logic isub,
                       output logic [15:0] es, output logic ec, output logic eo);
    logic [31:0] mask, full, bb, ua, ub;
    logic sa, sbb, ss;
    mask = (32'd1 << w) - 1;
    ua = {16'h0, ia} & mask;
    ub = {16'h0, ib} & mask;
    bb = isub ? (~ub & mask) : ub;
    full = ua + bb + {31'd0, isub};
    es = 16'(full & mask);
    ec = full[w];
    sa = ua[w-1]; sbb = ub[w-1]; ss = full[w-1];
    eo = isub ? ((sa != sbb) && (ss != sa)) : ((sa == sbb) && (ss != sa));
  endtask

  // One full transaction: accept, wait for result, measure latency, handshake.
  task automatic run_op(input int sel, input logic [15:0] ia, input logic [15:0] ib, input logic isub,
                        output logic [15:0] rs, output logic rc, output logic ro, output int lat);
    @(negedge clk);
    cur_sel = sel;
    #0;
    chk("in_ready_before_accept", 32'(m_ir), 32'd1);
    drive(sel, 1'b1, ia, ib, isub);
    @(posedge clk);
    #1;
    drive(sel, 1'b0, 16'h0, 16'h0, 1'b0);
    lat = 0;
    rs = '0; rc = 0; ro = 0;
    while (1) begin
      @(negedge clk);
      if (m_ov) break;
      if (lat >= 50) begin
        chk("out_valid_timeout", 32'd0, 32'd1);
        return;
      end
      @(posedge clk);
      lat++;
    end
    rs = m_s; rc = m_co; ro = m_of;
    set_ready(sel, 1'b1);
    @(posedge clk);
    #1;
    set_ready(sel, 1'b0);
    @(negedge clk);
    chk("in_ready_after_handshake", 32'(m_ir), 32'd1);
    chk("out_valid_after_handshake", 32'(m_ov), 32'd0);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] es;
    logic        ec;
    logic        eo;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [15:0] rs, es;
    logic        rc, ro, ec, eo;
    int          lat;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[7] = '{16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", 32'(ir0), 32'd1);
    chk("reset_out_valid", 32'(ov0), 32'd0);
    chk("reset_s", 32'(s0), 32'd0);
    chk("reset_cout", 32'(co0), 32'd0);
    chk("reset_ovf", 32'(of0), 32'd0);

    foreach (vecs[i]) begin
      run_op(0, vecs[i].a, vecs[i].b, vecs[i].sub, rs, rc, ro, lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
      chk($sformatf("vec%0d_s", i), 32'(rs), 32'(vecs[i].es));
      chk($sformatf("vec%0d_cout", i), 32'(rc), 32'(vecs[i].ec));
      chk($sformatf("vec%0d_ovf", i), 32'(ro), 32'(vecs[i].eo));
    end

    // Backpressure: result held while inputs churn, no new accept.
    cur_sel = 0;
    @(negedge clk);
    drive(0, 1'b1, 16'h1234, 16'h4321, 1'b0);
    @(posedge clk);
    #1 drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("bp_out_valid", 32'(ov0), 32'd1);
    for (int c = 0; c < 5; c++) begin
      drive(0, c[0], 16'(16'hA5A5 + c), 16'(16'h0F0F * c), c[1]);
      @(posedge clk);
      @(negedge clk);
      chk("bp_s", 32'(s0), 32'h5555);
      chk("bp_cout", 32'(co0), 32'd0);
      chk("bp_ovf", 32'(of0), 32'd0);
      chk("bp_in_ready", 32'(ir0), 32'd0);
      chk("bp_out_valid_held", 32'(ov0), 32'd1);
    end
    drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
    or0 = 1'b1;
    @(posedge clk);
    #1 or0 = 1'b0;
    @(negedge clk);
    chk("bp_release_in_ready", 32'(ir0), 32'd1);
    chk("bp_release_out_valid", 32'(ov0), 32'd0);

    // Reset at the second RUN edge discards the operation.
    drive(0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0);
    @(posedge clk);
    #1 drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_in_ready", 32'(ir0), 32'd1);
    chk("rst_mid_out_valid", 32'(ov0), 32'd0);
    chk("rst_mid_s", 32'(s0), 32'd0);
    run_op(0, 16'h0001, 16'h0001, 1'b0, rs, rc, ro, lat);
    chk("post_rst_s", 32'(rs), 32'h0002);
    chk("post_rst_cout", 32'(rc), 32'd0);

    // Parameter sweep against the reference model.
    for (int sel = 1; sel <= 2; sel++) begin
      int w, n;
      w = (sel == 1) ? 8 : 12;
      n = (sel == 1) ? 1 : 4;
      for (int t = 0; t < 16; t++) begin
        logic [15:0] ra, rb;
        logic        rsub;
        ra = 16'($urandom);
        rb = 16'($urandom);
        rsub = t[0];
        if (t == 2) begin ra = 16'hFFFF; rb = 16'h0001; end
        if (t == 3) begin ra = 16'h0000; rb = 16'h0001; end
        run_op(sel, ra, rb, rsub, rs, rc, ro, lat);
        model(w, ra, rb, rsub, es, ec, eo);
        chk($sformatf("w%0d_t%0d_latency", w, t), 32'(lat), 32'(n));
        chk($sformatf("w%0d_t%0d_s", w, t), 32'(rs), 32'(es));
        chk($sformatf("w%0d_t%0d_cout", w, t), 32'(rc), 32'(ec));
        chk($sformatf("w%0d_t%0d_ovf", w, t), 32'(ro), 32'(eo));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
